// File: rtl/id_table_pkg.sv
// id_table_pkg: shared read-FSM state and write-queue entry types for id_table_client.
// Entries are sized for ids up to ID_MAX bits and targets up to TGT_MAX bits.
package id_table_pkg;
   localparam int ID_MAX  = 16;
   localparam int TGT_MAX = 32;
   typedef enum logic {IDLE, ISSUE} rd_state_e;
   typedef struct packed {
      logic [ID_MAX-1:0]  id;
      logic [TGT_MAX-1:0] target;
   } wq_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: in-order FIFO, power-of-two depth, head data forced to zero while empty.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] dout
);
   localparam int P = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [P:0] rp, wp;
   assign empty = rp == wp;
   assign full  = (rp[P] != wp[P]) && (rp[P-1:0] == wp[P-1:0]);
   assign dout  = empty ? '0 : mem[rp[P-1:0]];
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         rp <= '0;
         wp <= '0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
      end
   always_ff @(posedge clk)
      if (push) mem[wp[P-1:0]] <= din;
endmodule

// File: rtl/id_table_client.sv
// id_table_client: queues table writes and issues hazard-safe table lookups.
// Build option ID_TABLE_CLIENT_FWD_EN: serve a hazarding lookup from the youngest queued record.
module id_table_client import id_table_pkg::*; #(
   parameter int D         = 16,
   parameter int WIDTH     = 32,
   parameter int LOG_D     = (D > 1) ? $clog2(D) : 1,
   parameter int WQ_DEPTH  = 4,
   parameter int RSP_DEPTH = 2
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             rec_vld_i,
   output logic             rec_rdy_o,
   input  logic [LOG_D-1:0] rec_id_i,
   input  logic [WIDTH-1:0] rec_target_i,
   input  logic             lkp_vld_i,
   output logic             lkp_rdy_o,
   input  logic [LOG_D-1:0] lkp_id_i,
   output logic             rsp_vld_o,
   input  logic             rsp_rdy_i,
   output logic [WIDTH-1:0] rsp_target_o,
   output logic             wrVld_o,
   input  logic             wrRdy_i,
   output logic [LOG_D-1:0] newId_o,
   output logic [WIDTH-1:0] newTarget_o,
   output logic             rdVld_o,
   input  logic             rdRdy_i,
   output logic [LOG_D-1:0] lookupId_o,
   input  logic [WIDTH-1:0] lookupTarget_i
);
`ifdef ID_TABLE_CLIENT_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif
   localparam int WP = $clog2(WQ_DEPTH);
   wq_entry_t wq [WQ_DEPTH];
   logic [WP:0] wq_head, wq_tail, wq_cnt;
   logic wq_push, wq_pop, wq_full;
   rd_state_e state, state_nxt;
   logic [LOG_D-1:0] lkp_id_q;
   logic hazard, rsp_push, rsp_full, rsp_empty;
   logic [WIDTH-1:0] fwd_target, rsp_din;
   assign wq_cnt  = wq_tail - wq_head;
   assign wq_full = wq_cnt[WP];
   assign wrVld_o = wq_cnt != '0;
   assign newId_o = wrVld_o ? LOG_D'(wq[wq_head[WP-1:0]].id) : '0;
   assign newTarget_o = wrVld_o ? WIDTH'(wq[wq_head[WP-1:0]].target) : '0;
   assign wq_push = rec_vld_i && rec_rdy_o;
   assign wq_pop  = wrVld_o && wrRdy_i;
   assign lookupId_o = lkp_id_q;
   assign rsp_vld_o  = !rsp_empty;
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         wq_head <= '0;
         wq_tail <= '0;
      end else begin
         if (wq_push) wq_tail <= wq_tail + 1'b1;
         if (wq_pop) wq_head <= wq_head + 1'b1;
      end
   always_ff @(posedge clk)
      if (wq_push) wq[wq_tail[WP-1:0]] <= '{id: ID_MAX'(rec_id_i), target: TGT_MAX'(rec_target_i)};
   // Oldest to youngest, so the last match left standing is the youngest record for the id.
   always_comb begin
      hazard = 1'b0;
      fwd_target = '0;
      for (int k = 0; k < WQ_DEPTH; k++)
         if ((WP+1)'(k) < wq_cnt && wq[wq_head[WP-1:0] + WP'(k)].id == ID_MAX'(lkp_id_q)) begin
            hazard = 1'b1;
            fwd_target = WIDTH'(wq[wq_head[WP-1:0] + WP'(k)].target);
         end
   end
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         state <= IDLE;
         lkp_id_q <= '0;
      end else begin
         state <= state_nxt;
         if (lkp_vld_i && lkp_rdy_o) lkp_id_q <= lkp_id_i;
      end
   always_comb
      state_nxt = (state == IDLE) ? ((lkp_vld_i && lkp_rdy_o) ? ISSUE : IDLE) : (rsp_push ? IDLE : ISSUE);
   always_comb begin
      rec_rdy_o = !wq_full && state != ISSUE;
      lkp_rdy_o = state == IDLE && !rsp_full;
      rdVld_o   = state == ISSUE && !hazard;
      rsp_push  = state == ISSUE && (hazard ? FWD : rdRdy_i);
      rsp_din   = hazard ? fwd_target : lookupTarget_i;
   end
   sync_fifo #(.WIDTH(WIDTH), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
      .clk  (clk),
      .rstn (rstn),
      .push (rsp_push),
      .din  (rsp_din),
      .pop  (rsp_vld_o && rsp_rdy_i),
      .full (rsp_full),
      .empty(rsp_empty),
      .dout (rsp_target_o)
   );
endmodule

// File: tb/tb_id_table_client.sv
// tb_id_table_client: scoreboard bench with a behavioural table behind the read/write ports.
module tb_id_table_client;
   localparam int D = 16, WIDTH = 32, LOG_D = 4, WQ_DEPTH = 4, RSP_DEPTH = 2;
   logic clk = 1'b0, rstn = 1'b0;
   logic rec_vld_i, rec_rdy_o, lkp_vld_i, lkp_rdy_o, rsp_vld_o, rsp_rdy_i;
   logic wrVld_o, wrRdy_i, rdVld_o, rdRdy_i;
   logic [LOG_D-1:0] rec_id_i, lkp_id_i, newId_o, lookupId_o;
   logic [WIDTH-1:0] rec_target_i, rsp_target_o, newTarget_o, lookupTarget_i;
   typedef struct packed {
      logic [LOG_D-1:0] id;
      logic [WIDTH-1:0] t;
   } wr_t;
   logic [WIDTH-1:0] tbl [D];
   logic [WIDTH-1:0] shadow [D];
   wr_t wr_q[$];
   logic [WIDTH-1:0] rsp_q[$];
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
   assign lookupTarget_i = tbl[lookupId_o];
   id_table_client #(.D(D), .WIDTH(WIDTH), .LOG_D(LOG_D), .WQ_DEPTH(WQ_DEPTH), .RSP_DEPTH(RSP_DEPTH)) dut (
      .clk(clk), .rstn(rstn),
      .rec_vld_i(rec_vld_i), .rec_rdy_o(rec_rdy_o), .rec_id_i(rec_id_i), .rec_target_i(rec_target_i),
      .lkp_vld_i(lkp_vld_i), .lkp_rdy_o(lkp_rdy_o), .lkp_id_i(lkp_id_i),
      .rsp_vld_o(rsp_vld_o), .rsp_rdy_i(rsp_rdy_i), .rsp_target_o(rsp_target_o),
      .wrVld_o(wrVld_o), .wrRdy_i(wrRdy_i), .newId_o(newId_o), .newTarget_o(newTarget_o),
      .rdVld_o(rdVld_o), .rdRdy_i(rdRdy_i), .lookupId_o(lookupId_o), .lookupTarget_i(lookupTarget_i)
   );
   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask
   // One cycle: observe this cycle's handshakes at the falling edge, then step past the rising edge.
   task automatic tick();
      wr_t e;
      logic [WIDTH-1:0] r;
      @(negedge clk);
      if (rstn) begin
         if (rec_vld_i && rec_rdy_o) begin
            wr_q.push_back('{rec_id_i, rec_target_i});
            shadow[rec_id_i] = rec_target_i;
         end
         if (lkp_vld_i && lkp_rdy_o) rsp_q.push_back(shadow[lkp_id_i]);
         if (wrVld_o && wrRdy_i) begin
            if (wr_q.size() == 0) check("wr_unexpected", 64'(wr_q.size()), 64'd1);
            else begin
               e = wr_q.pop_front();
               check("wr_id", 64'(newId_o), 64'(e.id));
               check("wr_target", 64'(newTarget_o), 64'(e.t));
            end
            tbl[newId_o] = newTarget_o;
         end
         if (rsp_vld_o && rsp_rdy_i) begin
            if (rsp_q.size() == 0) check("rsp_unexpected", 64'(rsp_q.size()), 64'd1);
            else begin
               r = rsp_q.pop_front();
               check("rsp_target", 64'(rsp_target_o), 64'(r));
            end
         end
      end
      @(posedge clk);
      #1;
   endtask
   task automatic rec(int id, logic [WIDTH-1:0] t);
      int n = 0;
      rec_vld_i = 1'b1; rec_id_i = LOG_D'(id); rec_target_i = t;
      while (!rec_rdy_o && n < 20) begin tick(); n++; end
      check("rec_accept", 64'(rec_rdy_o), 64'd1);
      tick();
      rec_vld_i = 1'b0;
   endtask
   task automatic lkp(int id);
      int n = 0;
      lkp_vld_i = 1'b1; lkp_id_i = LOG_D'(id);
      while (!lkp_rdy_o && n < 20) begin tick(); n++; end
      check("lkp_accept", 64'(lkp_rdy_o), 64'd1);
      tick();
      lkp_vld_i = 1'b0;
   endtask
   task automatic drain();
      int n = 0;
      wrRdy_i = 1'b1; rdRdy_i = 1'b1; rsp_rdy_i = 1'b1;
      while ((wr_q.size() != 0 || rsp_q.size() != 0) && n < 100) begin tick(); n++; end
      check("drain_wr", 64'(wr_q.size()), 64'd0);
      check("drain_rsp", 64'(rsp_q.size()), 64'd0);
   endtask
   task automatic check_reset(string tag);
      check({tag, "_vld"}, 64'({wrVld_o, rdVld_o, rsp_vld_o}), 64'd0);
      check({tag, "_rdy"}, 64'({rec_rdy_o, lkp_rdy_o}), 64'd3);
      check({tag, "_new_id"}, 64'(newId_o), 64'd0);
      check({tag, "_new_target"}, 64'(newTarget_o), 64'd0);
      check({tag, "_lookup_id"}, 64'(lookupId_o), 64'd0);
      check({tag, "_rsp_target"}, 64'(rsp_target_o), 64'd0);
   endtask
   initial begin
      rec_vld_i = 1'b0; rec_id_i = '0; rec_target_i = '0;
      lkp_vld_i = 1'b0; lkp_id_i = '0;
      wrRdy_i = 1'b1; rdRdy_i = 1'b1; rsp_rdy_i = 1'b1;
      for (int i = 0; i < D; i++) tbl[i] = 32'h1000 + i;
      tbl[7] = 32'h11;
      shadow = tbl;
      #1 check_reset("rst");
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      // single record drains in one cycle
      check("t1_idle", 64'(wrVld_o), 64'd0);
      rec(3, 32'hA5);
      check("t1_wr_vld", 64'(wrVld_o), 64'd1);
      check("t1_wr_id", 64'(newId_o), 64'd3);
      check("t1_wr_target", 64'(newTarget_o), 64'hA5);
      tick();
      check("t1_empty", 64'(wrVld_o), 64'd0);
      // fill the write queue, fifth record waits for the drain
      wrRdy_i = 1'b0;
      for (int i = 0; i < 4; i++) rec(i + 1, 32'h100 + i);
      check("t2_full", 64'(rec_rdy_o), 64'd0);
      wrRdy_i = 1'b1;
      rec(5, 32'h104);
      drain();
      // plain lookup latency
      lkp(7);
      check("t3_n1_rd", 64'(rdVld_o), 64'd1);
      check("t3_n1_rsp", 64'(rsp_vld_o), 64'd0);
      tick();
      check("t3_n2_rsp", 64'(rsp_vld_o), 64'd1);
      check("t3_n2_target", 64'(rsp_target_o), 64'h11);
      drain();
      // lookup of an id still sitting in the write queue
      wrRdy_i = 1'b0;
      rec(5, 32'h22);
      lkp(5);
`ifdef ID_TABLE_CLIENT_FWD_EN
      check("t4_fwd_rd", 64'(rdVld_o), 64'd0);
      tick();
      check("t4_fwd_rsp", 64'(rsp_vld_o), 64'd1);
      check("t4_fwd_target", 64'(rsp_target_o), 64'h22);
      check("t4_fwd_no_rd", 64'(rdVld_o), 64'd0);
`else
      for (int i = 0; i < 3; i++) begin
         check("t4_stall", 64'(rdVld_o), 64'd0);
         tick();
      end
      wrRdy_i = 1'b1;
      check("t4_pop_cycle", 64'(rdVld_o), 64'd0);
      tick();
      check("t4_after_pop", 64'(rdVld_o), 64'd1);
`endif
      drain();
      // response FIFO full blocks lookups
      rsp_rdy_i = 1'b0;
      lkp(1);
      lkp(2);
      tick(); tick();
      check("t5_blocked", 64'(lkp_rdy_o), 64'd0);
      check("t5_rsp_vld", 64'(rsp_vld_o), 64'd1);
      rsp_rdy_i = 1'b1;
      tick();
      rsp_rdy_i = 1'b0;
      check("t5_reenabled", 64'(lkp_rdy_o), 64'd1);
      drain();
      // reset while a read is outstanding and records are queued
      wrRdy_i = 1'b0; rdRdy_i = 1'b0;
      for (int i = 0; i < 3; i++) rec(8 + i, 32'h200 + i);
      lkp(2);
      check("t6_issue", 64'(rdVld_o), 64'd1);
      rstn = 1'b0;
      #1 check_reset("t6");
      wr_q.delete(); rsp_q.delete(); shadow = tbl;
      wrRdy_i = 1'b1; rdRdy_i = 1'b1; rsp_rdy_i = 1'b1;
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("t6_quiet", 64'({wrVld_o, rdVld_o, rsp_vld_o}), 64'd0);
         tick();
      end
      // random traffic on a small id range to provoke hazards
      for (int c = 0; c < 300; c++) begin
         rec_vld_i = 1'($urandom_range(0, 1)); rec_id_i = LOG_D'($urandom_range(0, 3)); rec_target_i = $urandom;
         lkp_vld_i = 1'($urandom_range(0, 1)); lkp_id_i = LOG_D'($urandom_range(0, 3));
         wrRdy_i = 1'($urandom_range(0, 1)); rdRdy_i = 1'($urandom_range(0, 1)); rsp_rdy_i = 1'($urandom_range(0, 1));
         tick();
      end
      rec_vld_i = 1'b0; lkp_vld_i = 1'b0;
      drain();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/id_table_client.md
ID_TABLE_CLIENT -- requirements
Module: id_table_client

Interface
REQ-001 SHALL have parameter D, default 16: ID table depth.
REQ-002 SHALL have parameter WIDTH, default 32: target width.
REQ-003 SHALL have parameter LOG_D, default (D>1)?$clog2(D):1: ID width.
REQ-004 SHALL have parameter WQ_DEPTH, default 4, power of two ≥2: write-queue entries.
REQ-005 SHALL have parameter RSP_DEPTH, default 2, power of two ≥2: response-FIFO entries.
REQ-006 SHALL have ports, one per line: name, direction, width, meaning.
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- rec_vld_i / rec_rdy_o  in / out  1  record request handshake
- rec_id_i  in  LOG_D  ID to record
- rec_target_i  in  WIDTH  target to record
- lkp_vld_i / lkp_rdy_o  in / out  1  lookup request handshake
- lkp_id_i  in  LOG_D  ID to look up
- rsp_vld_o / rsp_rdy_i  out / in  1  lookup response handshake
- rsp_target_o  out  WIDTH  looked-up target
- wrVld_o / wrRdy_i  out / in  1  table write-port handshake
- newId_o  out  LOG_D  table write address
- newTarget_o  out  WIDTH  table write data
- rdVld_o / rdRdy_i  out / in  1  table read-port handshake
- lookupId_o  out  LOG_D  table read address
- lookupTarget_i  in  WIDTH  table read data, valid in the cycle rdVld_o&&rdRdy_i

Function
REQ-007 SHALL transfer on every interface only in a cycle where vld&&rdy are both high.
REQ-008 SHALL hold wrVld_o, newId_o and newTarget_o stable until wrRdy_i; the same rule SHALL apply to rdVld_o and lookupId_o until rdRdy_i.
REQ-009 Write queue SHALL be an in-order FIFO of WQ_DEPTH {id,target} entries.
- rec_rdy_o = !full && rd_state!=ISSUE
- wrVld_o = !empty, with the head driving newId_o/newTarget_o
- pop on wrVld_o&&wrRdy_i
- simultaneous push and pop leaves the count unchanged
REQ-010 Read FSM SHALL have states IDLE and ISSUE.
- lkp_rdy_o = (state==IDLE) && rsp_count<RSP_DEPTH
- on lookup accept: lookup ID is registered, state goes IDLE->ISSUE
REQ-011 In ISSUE, hazard SHALL be asserted when any valid write-queue entry (including a head being popped this cycle) has an id equal to the registered lookup ID.
REQ-012 In ISSUE without hazard, the block SHALL drive rdVld_o=1 and lookupId_o=the registered ID.
- on rdRdy_i: push lookupTarget_i into the response FIFO, ISSUE->IDLE
REQ-013 Response FIFO SHALL be in-order with RSP_DEPTH entries.
- rsp_vld_o = !empty, with the head driving rsp_target_o
- pop on rsp_vld_o&&rsp_rdy_i
- push and pop may coincide
REQ-014 Latency: lookup accepted in cycle N, granted in cycle N+1, SHALL give rsp_vld_o in cycle N+2; each cycle without rdRdy_i SHALL add one cycle.
REQ-015 Ordering: a record accepted in the same cycle as, or before, a lookup of the same ID SHALL be visible to that lookup.
REQ-016 The block SHALL keep at most one table read outstanding; rdVld_o SHALL be 0 outside ISSUE.

Reset
REQ-017 On rstn low, all outputs SHALL take these values, asynchronously:
- both queues empty, state IDLE
- wrVld_o=0, rdVld_o=0, rsp_vld_o=0
- rec_rdy_o=1, lkp_rdy_o=1
- newId_o, newTarget_o, lookupId_o, rsp_target_o all 0
REQ-018 Reset asserted mid-operation SHALL discard queued records, the in-flight lookup and pending responses without emitting any further handshake.

Configuration
REQ-019 Macro ID_TABLE_CLIENT_FWD_EN SHALL be the single build option.
- Defined: in ISSUE with hazard, push the target of the youngest matching write-queue entry into the response FIFO, go ISSUE->IDLE, no table read (latency N+2).
- Undefined: in ISSUE with hazard, hold rdVld_o=0 until hazard clears, then proceed per REQ-012.

Structure
REQ-020 Package id_table_pkg SHALL hold:
- the read-FSM state enum (IDLE, ISSUE)
- a packed wq_entry_t {id,target}, parameterised by localparams
REQ-021 The response FIFO SHALL be the sub-module sync_fifo (width WIDTH, depth RSP_DEPTH).
REQ-022 The write queue SHALL be coded inline, because all of its entries feed the hazard compare.

Verification
REQ-023 Record id=3,target=0xA5 with wrRdy_i tied 1 -> wrVld_o for 1 cycle, newId_o=3, newTarget_o=0xA5, queue empty afterwards.
REQ-024 wrRdy_i=0; 5 records with WQ_DEPTH=4 -> rec_rdy_o=0 after the 4th; releasing wrRdy_i drains ids in order.
REQ-025 Lookup id=7, rdRdy_i=1, lookupTarget_i=0x11 -> rsp_vld_o in cycle N+2 with rsp_target_o=0x11.
REQ-026 Record id=5,target=0x22 held by wrRdy_i=0, then lookup id=5:
- FWD_EN defined: rsp_target_o=0x22 with no rdVld_o
- FWD_EN undefined: rdVld_o stays 0 until one cycle after the write pops
REQ-027 rsp_rdy_i=0 with 2 lookups completed -> lkp_rdy_o=0; one pop re-enables it.
REQ-028 rstn asserted while in ISSUE with 3 queued records -> all outputs at reset values immediately, no handshake follows.
